// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache line-refill engine: one 8-beat INCR burst per miss, 256-bit line return
//
// Purpose:
//    Accepts a single-cycle miss request from the instruction cache. It issues one
//    8-beat, 32-bit INCR burst read on an AXI4-style read channel. The beats are
//    assembled into a 256-bit line, which is returned with a one-cycle acknowledge.
//    At most one refill is outstanding. Requests that arrive while busy are dropped.
//
// Optional feature macro: ICACHE_REFILL_CHK_EN
//    When defined, a sticky error flag records two conditions. The first is any
//    accepted beat with a non-OKAY response. The second is an rlast that disagrees
//    with the beat count. The flag is reported on refill_err in the acknowledge
//    cycle. When undefined, refill_err is tied to 0 and no error logic exists.
//
// Ports:
//    clk               in   sole clock, rising edge
//    rst               in   synchronous active-high reset
//    icache_l2_rreq    in   refill request pulse
//    icache_l2_raddr   in   [63:0] miss address (any byte in the line)
//    l2_icache_rask    out  one-cycle line-valid acknowledge
//    l2_icache_rdata   out  [7:0][31:0] assembled line, word i = line byte offset 4*i
//    refill_err        out  error flag, qualified by l2_icache_rask
//    mem_arvalid       out  read-address valid
//    mem_arready       in   read-address ready
//    mem_araddr        out  [ADDR_W-1:0] line-aligned burst address
//    mem_arlen         out  [7:0] constant 7 (8 beats)
//    mem_arsize        out  [2:0] constant 3'b010 (4 bytes)
//    mem_arburst       out  [1:0] constant 2'b01 (INCR)
//    mem_rvalid        in   read-data valid
//    mem_rready        out  read-data ready
//    mem_rdata         in   [31:0] beat data
//    mem_rresp         in   [1:0] beat response
//    mem_rlast         in   last-beat marker

module icache_refill #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_l2_rreq,
   input  logic [63:0]       icache_l2_raddr,
   output logic              l2_icache_rask,
   output logic [7:0][31:0]  l2_icache_rdata,
   output logic              refill_err,
   output logic              mem_arvalid,
   input  logic              mem_arready,
   output logic [ADDR_W-1:0] mem_araddr,
   output logic [7:0]        mem_arlen,
   output logic [2:0]        mem_arsize,
   output logic [1:0]        mem_arburst,
   input  logic              mem_rvalid,
   output logic              mem_rready,
   input  logic [31:0]       mem_rdata,
   input  logic [1:0]        mem_rresp,
   input  logic              mem_rlast
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_cnt;
   logic [7:0][31:0]    r_line;
   logic                w_accept;
   logic                w_beat;
   logic                w_unused_addr;

   // Every output is a decode of registered state. No input reaches an output combinationally.
   assign w_accept        = (r_state == ST_IDLE) && icache_l2_rreq;
   assign w_beat          = (r_state == ST_R) && mem_rvalid;
   assign mem_arvalid     = (r_state == ST_AR);
   assign mem_rready      = (r_state == ST_R);
   assign l2_icache_rask  = (r_state == ST_DONE);
   assign mem_araddr      = r_addr;
   assign l2_icache_rdata = r_line;
   assign mem_arlen       = 8'd7;
   assign mem_arsize      = 3'b010;
   assign mem_arburst     = 2'b01;

   // The upper address bits beyond ADDR_W are unused. So are the five line-offset bits.
   assign w_unused_addr   = ^icache_l2_raddr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (icache_l2_rreq)        w_next = ST_AR;
         ST_AR:   if (mem_arready)           w_next = ST_R;
         // The burst ends on the beat count alone. rlast does not steer the FSM.
         ST_R:    if (w_beat && r_cnt == 3'd7) w_next = ST_DONE;
         ST_DONE:                            w_next = ST_IDLE;
         default:                            w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= '0;
         r_cnt  <= 3'd0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= {icache_l2_raddr[ADDR_W-1:5], 5'b0};
            r_cnt  <= 3'd0;
         end
         // The line keeps its old contents until beat 0 of the next refill lands.
         if (w_beat) begin
            r_line[r_cnt] <= mem_rdata;
            r_cnt         <= r_cnt + 3'd1;
         end
      end
   end

`ifdef ICACHE_REFILL_CHK_EN
   logic r_err;
   logic w_beat_bad;

   assign w_beat_bad = (mem_rresp != 2'b00) || (mem_rlast != (r_cnt == 3'd7));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if (w_beat && w_beat_bad) begin
         r_err <= 1'b1;
      end
   end

   assign refill_err = l2_icache_rask && r_err;
`else
   logic w_unused_chk;

   assign w_unused_chk = ^{mem_rresp, mem_rlast};
   assign refill_err   = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill

module tb_icache_refill;

   logic              clk;
   logic              rst;
   logic              icache_l2_rreq;
   logic [63:0]       icache_l2_raddr;
   logic              l2_icache_rask;
   logic [7:0][31:0]  l2_icache_rdata;
   logic              refill_err;
   logic              mem_arvalid;
   logic              mem_arready;
   logic [31:0]       mem_araddr;
   logic [7:0]        mem_arlen;
   logic [2:0]        mem_arsize;
   logic [1:0]        mem_arburst;
   logic              mem_rvalid;
   logic              mem_rready;
   logic [31:0]       mem_rdata;
   logic [1:0]        mem_rresp;
   logic              mem_rlast;

   int passed = 0;
   int total  = 0;
   int lat_r;
   int ar_cnt;
   logic err_r;
   logic seen_r;
   logic exp_chk_err;

   icache_refill #(.ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .icache_l2_rreq  (icache_l2_rreq),
      .icache_l2_raddr (icache_l2_raddr),
      .l2_icache_rask  (l2_icache_rask),
      .l2_icache_rdata (l2_icache_rdata),
      .refill_err      (refill_err),
      .mem_arvalid     (mem_arvalid),
      .mem_arready     (mem_arready),
      .mem_araddr      (mem_araddr),
      .mem_arlen       (mem_arlen),
      .mem_arsize      (mem_arsize),
      .mem_arburst     (mem_arburst),
      .mem_rvalid      (mem_rvalid),
      .mem_rready      (mem_rready),
      .mem_rdata       (mem_rdata),
      .mem_rresp       (mem_rresp),
      .mem_rlast       (mem_rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_line(input logic [31:0] base);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("word%0d", i), 64'(l2_icache_rdata[i]), 64'(base + 32'(i)));
      end
   endtask

   // Run one refill from a negedge. Beat b carries data base+b. A negative beat index disables that feature.
   task automatic refill(input logic [63:0] addr, input logic [31:0] exp_ar, input logic [31:0] base,
                         input int ar_stall, input int gap_beat, input int gap_len,
                         input int err_beat, input int rlast_beat, input int inj_beat,
                         input int rst_beat);
      int   cyc;
      int   beat;
      int   ar_wait;
      int   gap_left;
      logic done;
      logic aborted;
      cyc = 0; beat = 0; ar_wait = 0; gap_left = gap_len;
      done = 1'b0; aborted = 1'b0;
      seen_r = 1'b0; err_r = 1'b0; lat_r = 0; ar_cnt = 0;
      @(negedge clk);
      icache_l2_rreq  = 1'b1;
      icache_l2_raddr = addr;
      @(posedge clk);
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         cyc++;
         icache_l2_rreq  = 1'b0;
         icache_l2_raddr = 64'h0;
         mem_arready     = 1'b0;
         mem_rvalid      = 1'b0;
         mem_rdata       = 32'h0;
         mem_rresp       = 2'b00;
         mem_rlast       = 1'b0;
         if (l2_icache_rask) begin
            lat_r  = cyc;
            err_r  = refill_err;
            seen_r = 1'b1;
            done   = 1'b1;
         end else begin
            if (mem_arvalid) begin
               chk("araddr", 64'(mem_araddr), 64'(exp_ar));
               chk("rready_in_ar", 64'(mem_rready), 64'h0);
               chk("err_outside_rask", 64'(refill_err), 64'h0);
               if (ar_wait >= ar_stall) begin
                  mem_arready = 1'b1;
                  ar_cnt++;
               end
               ar_wait++;
            end
            if (mem_rready) begin
               if (beat == rst_beat) begin
                  rst = 1'b1;
                  @(posedge clk);
                  @(negedge clk);
                  rst = 1'b0;
                  chk("rst_arvalid", 64'(mem_arvalid), 64'h0);
                  chk("rst_rready", 64'(mem_rready), 64'h0);
                  chk("rst_rask", 64'(l2_icache_rask), 64'h0);
                  chk("rst_err", 64'(refill_err), 64'h0);
                  chk("rst_araddr", 64'(mem_araddr), 64'h0);
                  chk("rst_line_zero", 64'(l2_icache_rdata == '0), 64'h1);
                  done    = 1'b1;
                  aborted = 1'b1;
               end else if (beat == gap_beat && gap_left > 0) begin
                  gap_left--;
               end else begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = base + 32'(beat);
                  mem_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                  mem_rlast  = (beat == rlast_beat);
                  if (beat == inj_beat) begin
                     icache_l2_rreq  = 1'b1;
                     icache_l2_raddr = 64'hDEAD_BEE0;
                  end
                  beat++;
               end
            end
         end
         if (!done) @(posedge clk);
      end
      if (!aborted) chk("rask_seen", 64'(seen_r), 64'h1);
   endtask

   initial begin
`ifdef ICACHE_REFILL_CHK_EN
      exp_chk_err = 1'b1;
`else
      exp_chk_err = 1'b0;
`endif
      rst = 1'b1;
      icache_l2_rreq = 1'b0; icache_l2_raddr = 64'h0;
      mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      mem_rresp = 2'b00; mem_rlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_arvalid", 64'(mem_arvalid), 64'h0);
      chk("reset_rready", 64'(mem_rready), 64'h0);
      chk("reset_rask", 64'(l2_icache_rask), 64'h0);
      chk("reset_err", 64'(refill_err), 64'h0);
      chk("reset_araddr", 64'(mem_araddr), 64'h0);
      chk("reset_line_zero", 64'(l2_icache_rdata == '0), 64'h1);
      chk("arlen", 64'(mem_arlen), 64'd7);
      chk("arsize", 64'(mem_arsize), 64'd2);
      chk("arburst", 64'(mem_arburst), 64'd1);
      rst = 1'b0;

      // Minimum-latency refill
      refill(64'h8000_1234, 32'h8000_1220, 32'h100, 0, -1, 0, -1, 7, -1, -1);
      chk("t1_latency", 64'(lat_r), 64'd10);
      chk("t1_err", 64'(err_r), 64'h0);
      chk("t1_ar_count", 64'(ar_cnt), 64'd1);
      check_line(32'h100);

      // AR stall of 5 cycles plus a 3-cycle data gap before beat 4
      refill(64'h4000_00FC, 32'h4000_00E0, 32'h2000, 5, 4, 3, -1, 7, -1, -1);
      chk("t2_latency", 64'(lat_r), 64'd18);
      chk("t2_ar_count", 64'(ar_cnt), 64'd1);
      check_line(32'h2000);

      // A request injected during R is dropped
      refill(64'h0000_0000_1234_5678, 32'h1234_5660, 32'h300, 0, -1, 0, -1, 7, 3, -1);
      chk("t3_latency", 64'(lat_r), 64'd10);
      chk("t3_ar_count", 64'(ar_cnt), 64'd1);
      check_line(32'h300);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_no_ar", 64'(mem_arvalid), 64'h0);
         chk("idle_hold_w0", 64'(l2_icache_rdata[0]), 64'h300);
         chk("idle_hold_w7", 64'(l2_icache_rdata[7]), 64'h307);
      end
      refill(64'h1000_0040, 32'h1000_0040, 32'h400, 0, -1, 0, -1, 7, -1, -1);
      chk("t3b_latency", 64'(lat_r), 64'd10);
      check_line(32'h400);

      // Reset asserted at beat 4, then a clean refill
      refill(64'h2222_2200, 32'h2222_2200, 32'h500, 0, -1, 0, -1, 7, -1, 4);
      refill(64'h3333_331F, 32'h3333_3300, 32'h600, 0, -1, 0, -1, 7, -1, -1);
      chk("t4_latency", 64'(lat_r), 64'd10);
      check_line(32'h600);

      // SLVERR on beat 3, then a clean refill
      refill(64'h5000_0000, 32'h5000_0000, 32'h700, 0, -1, 0, 3, 7, -1, -1);
      chk("t5_err", 64'(err_r), 64'(exp_chk_err));
      check_line(32'h700);
      refill(64'h5000_0020, 32'h5000_0020, 32'h800, 0, -1, 0, -1, 7, -1, -1);
      chk("t5_clean_err", 64'(err_r), 64'h0);

      // Early rlast on beat 6. The refill still completes by count.
      refill(64'h6000_0008, 32'h6000_0000, 32'h900, 0, -1, 0, -1, 6, -1, -1);
      chk("t6_err", 64'(err_r), 64'(exp_chk_err));
      chk("t6_latency", 64'(lat_r), 64'd10);
      check_line(32'h900);

      @(negedge clk);
      chk("final_err_lo", 64'(refill_err), 64'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
# icache_refill

Line-refill engine directly downstream of the instruction cache. On an icache miss request it issues one 8-beat INCR burst read on an AXI4-style read channel to memory and assembles the 32-bit beats into a 256-bit line. It returns the line to the icache with a single-cycle acknowledge. It owns no storage beyond one line buffer and holds at most one refill outstanding.

## Interface
Parameters:
- ADDR_W, 32, memory-side address width; `mem_araddr = icache_l2_raddr[ADDR_W-1:0]` with bits [4:0] forced to 0.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_l2_rreq`  in  1  refill request. Single-cycle pulse from the icache. Address valid only in that cycle.
- `icache_l2_raddr`  in  64  miss address, any byte within the line.
- `l2_icache_rask`  out  1  one-cycle pulse; line valid on `l2_icache_rdata` in this cycle.
- `l2_icache_rdata`  out  [7:0][31:0]  assembled line; word i holds the beat at line byte offset 4*i.
- `refill_err`  out  1  error flag, qualified by `l2_icache_rask`. See Configuration.
- `mem_arvalid` / `mem_arready`  out/in  1  read-address handshake.
- `mem_araddr`  out  ADDR_W  line-aligned burst address.
- `mem_arlen`  out  8  constant 7.
- `mem_arsize`  out  3  constant 3'b010.
- `mem_arburst`  out  2  constant 2'b01 (INCR).
- `mem_rvalid` / `mem_rready`  in/out  1  read-data handshake.
- `mem_rdata`  in  32  beat data.
- `mem_rresp`  in  2  beat response.
- `mem_rlast`  in  1  last-beat marker.

## Operation
- State machine IDLE, AR, R, DONE. Encoding is free; states are registered.
- IDLE: on `icache_l2_rreq`, latch `{raddr[ADDR_W-1:5],5'b0}`, clear beat counter and error flag, go to AR.
- IDLE: `icache_l2_rreq` in any other state is ignored. No queueing.
- AR: `mem_arvalid`=1 with stable `mem_araddr`. On `mem_arready`, go to R. `mem_arvalid` is 0 in all other states.
- R: `mem_rready`=1. `mem_rready` is 0 in all other states.
- R: each accepted beat (`rvalid & rready`) writes `mem_rdata` into line word[cnt], where cnt is a 3-bit counter, then increments cnt.
- R: when the beat with cnt==7 is accepted, go to DONE. Termination is by count only.
- DONE: `l2_icache_rask`=1 for exactly this cycle, then go to IDLE.
- `l2_icache_rdata` is driven from the line register at all times. It holds its value until the first beat of the next refill overwrites word 0.
- No critical-word-first and no wrap bursts. The icache selects its word from the full line.

## Timing
- Reset values: state IDLE; `mem_arvalid`, `mem_rready`, `l2_icache_rask`, `refill_err` = 0; `mem_araddr` = 0; line register = 0; cnt = 0.
- Minimum latency, counted from the rreq cycle T (ready and valid asserted back to back):
  - `mem_arvalid` asserted in T+1 and accepted in T+1.
  - Beats accepted in T+2..T+9.
  - `l2_icache_rask` in T+10.
- Memory stalls (`arready`/`rvalid` low) add cycles one-for-one. There is no timeout.
- AR holds `arvalid` and `araddr` stable until accepted, per AXI.
- Reset asserted mid-AR or mid-R: the next cycle is IDLE with all outputs at reset values. Partially filled line contents are lost. Draining of the abandoned burst is the system reset's responsibility.
- No combinational path from any input to any output except through state registers. `mem_rready` is a decode of state.

## Configuration
- `ICACHE_REFILL_CHK_EN` defined:
  - A sticky error flag is set by any accepted beat with `mem_rresp != 2'b00`.
  - It is also set by `mem_rlast` mismatching (cnt==7).
  - `refill_err` equals the flag during the `l2_icache_rask` cycle and is 0 otherwise.
  - The flag clears on the next accepted request.
  - Data is still delivered; the refill still completes after 8 beats.
- `ICACHE_REFILL_CHK_EN` undefined:
  - `mem_rresp` and `mem_rlast` are ignored.
  - `refill_err` is tied to 0.
  - No error logic is synthesised.

## Test plan
- rreq with raddr=64'h8000_1234, memory always ready, beats 32'h100+i -> `mem_araddr`=32'h8000_1220, arlen=7, rask in exactly T+10, rdata[i]=32'h100+i.
- arready held low 5 cycles and one 3-cycle rvalid gap mid-burst -> rask at T+18, arvalid/araddr stable while stalled, line correct.
- Second rreq while in R, then a normal back-to-back refill after DONE -> the first request is unaffected and no extra AR is issued; the second line replaces the first and rdata holds between refills.
- rst asserted at beat 4 -> next cycle IDLE, all outputs 0, line=0; a subsequent rreq completes normally.
- With `ICACHE_REFILL_CHK_EN`, beat 3 rresp=2'b10 -> rask with refill_err=1. Next clean refill -> refill_err=0.
- With `ICACHE_REFILL_CHK_EN`, rlast asserted on beat 6 -> refill_err=1 at rask. Without the macro, the same stimulus gives refill_err=0.
